// File: rtl/adder_serial_pkg.sv
// Shared types and elaboration helpers for the serial chunked adder.
// Imported by adder_serial_n and adder_chunk.
package adder_serial_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } adder_state_t;

  function automatic int nch(input int n, input int chunk);
    return n / chunk;
  endfunction

  // A single-slice adder still needs a one-bit index register.
  function automatic int idxWidth(input int slices);
    return (slices > 1) ? $clog2(slices) : 1;
  endfunction

endpackage

// File: rtl/adder_serial_n_chunk.sv
// Purely combinational W-bit ripple-carry adder; one slice of the serial adder.
module adder_chunk
  import adder_serial_pkg::*;
#(
  parameter int W = 2
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic carry;

  always_comb begin
    s     = '0;
    carry = cin;
    for (int i = 0; i < W; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/adder_serial_n.sv
// Multi-cycle N-bit adder: one CHUNK-bit slice per clock, LSB first, valid/ready on both sides.
// Optional subtract mode (a - b) is enabled by defining ADDER_SERIAL_SUB_EN.
module adder_serial_n
  import adder_serial_pkg::*;
#(
  parameter int N     = 8,
  parameter int CHUNK = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         i_ready,
`ifdef ADDER_SERIAL_SUB_EN
  input  logic         sub,
`endif
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         overflow
);

  localparam int NCH = nch(N, CHUNK);
  localparam int IW  = idxWidth(NCH);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

  if (N < 1 || CHUNK < 1 || CHUNK > N || (N % CHUNK) != 0) begin : g_badParams
    $error("adder_serial_n: illegal parameters N=%0d CHUNK=%0d", N, CHUNK);
  end

  adder_state_t   state_q;
  logic [N-1:0]   opA_q;
  logic [N-1:0]   opB_q;
  logic           carry_q;
  logic [IW-1:0]  idx_q;
  logic [N-1:0]   sum_q;
  logic [N-1:0]   sum_d;
  logic           cout_q;
  logic           ovf_q;

  logic [CHUNK-1:0] chunkA;
  logic [CHUNK-1:0] chunkB;
  logic [CHUNK-1:0] chunkSum;
  logic             chunkCout;

  assign chunkA = opA_q[int'(idx_q) * CHUNK +: CHUNK];
  assign chunkB = opB_q[int'(idx_q) * CHUNK +: CHUNK];

  adder_chunk #(.W(CHUNK)) u_chunk (
    .a    (chunkA),
    .b    (chunkB),
    .cin  (carry_q),
    .s    (chunkSum),
    .cout (chunkCout)
  );

  // Sum with the current slice merged in; its MSB feeds the overflow decision.
  always_comb begin
    sum_d = sum_q;
    sum_d[int'(idx_q) * CHUNK +: CHUNK] = chunkSum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      opA_q   <= '0;
      opB_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            opA_q <= a;
`ifdef ADDER_SERIAL_SUB_EN
            opB_q   <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
`else
            opB_q   <= b;
            carry_q <= cin;
`endif
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            state_q <= S_ADD;
          end
        end
        S_ADD: begin
          sum_q   <= sum_d;
          carry_q <= chunkCout;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            cout_q  <= chunkCout;
            ovf_q   <= (opA_q[N-1] == opB_q[N-1]) && (sum_d[N-1] != opA_q[N-1]);
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (o_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign i_ready  = (state_q == S_IDLE);
  assign o_valid  = (state_q == S_DONE);
  assign s        = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_adder_serial_n.sv
// Self-checking bench for adder_serial_n: three configurations (8/2, 4/4, 6/1) against an arithmetic model.
// Subtract vectors are exercised when ADDER_SERIAL_SUB_EN is defined.
module tb_adder_serial_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       iValid;
  logic       oReady;
  logic [7:0] aIn;
  logic [7:0] bIn;
  logic       cinIn;
`ifdef ADDER_SERIAL_SUB_EN
  logic       subIn;
`endif
  int         sel;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] expS;
  logic       expCout;
  logic       expOvf;

  logic       iValid0, iValid1, iValid2;
  logic       iReady0, iReady1, iReady2;
  logic       oValid0, oValid1, oValid2;
  logic [7:0] s0;
  logic [3:0] s1;
  logic [5:0] s2;
  logic       cout0, cout1, cout2;
  logic       ovf0, ovf1, ovf2;

  logic [7:0] obsS;
  logic       obsCout, obsOvf, obsIReady, obsOValid;

  always #5 clk = ~clk;

  assign iValid0 = iValid && (sel == 0);
  assign iValid1 = iValid && (sel == 1);
  assign iValid2 = iValid && (sel == 2);

  adder_serial_n #(.N(8), .CHUNK(2)) dut (
    .clk(clk), .rst(rst), .i_valid(iValid0), .i_ready(iReady0),
`ifdef ADDER_SERIAL_SUB_EN
    .sub(subIn),
`endif
    .a(aIn), .b(bIn), .cin(cinIn), .o_valid(oValid0), .o_ready(oReady),
    .s(s0), .cout(cout0), .overflow(ovf0)
  );

  adder_serial_n #(.N(4), .CHUNK(4)) dut4 (
    .clk(clk), .rst(rst), .i_valid(iValid1), .i_ready(iReady1),
`ifdef ADDER_SERIAL_SUB_EN
    .sub(subIn),
`endif
    .a(aIn[3:0]), .b(bIn[3:0]), .cin(cinIn), .o_valid(oValid1), .o_ready(oReady),
    .s(s1), .cout(cout1), .overflow(ovf1)
  );

  adder_serial_n #(.N(6), .CHUNK(1)) dut6 (
    .clk(clk), .rst(rst), .i_valid(iValid2), .i_ready(iReady2),
`ifdef ADDER_SERIAL_SUB_EN
    .sub(subIn),
`endif
    .a(aIn[5:0]), .b(bIn[5:0]), .cin(cinIn), .o_valid(oValid2), .o_ready(oReady),
    .s(s2), .cout(cout2), .overflow(ovf2)
  );

  // Route the selected instance's outputs onto a common set of observation signals.
  always_comb begin
    obsS = s0; obsCout = cout0; obsOvf = ovf0; obsIReady = iReady0; obsOValid = oValid0;
    case (sel)
      1: begin obsS = {4'b0, s1}; obsCout = cout1; obsOvf = ovf1; obsIReady = iReady1; obsOValid = oValid1; end
      2: begin obsS = {2'b0, s2}; obsCout = cout2; obsOvf = ovf2; obsIReady = iReady2; obsOValid = oValid2; end
      default: ;
    endcase
  end

  function automatic int widthOf(input int k);
    return (k == 0) ? 8 : (k == 1) ? 4 : 6;
  endfunction

  function automatic int latencyOf(input int k);
    return (k == 0) ? 4 : (k == 1) ? 1 : 6;
  endfunction

  // Arithmetic reference: unsigned sum for s/cout, signed range test for overflow.
  task automatic refModel(input int n, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic sb,
                          output logic [7:0] rs, output logic rc, output logic ro);
    int mask, ua, ub, bEff, full, sa, sbv, sr;
    mask = (1 << n) - 1;
    ua   = int'(a) & mask;
    ub   = int'(b) & mask;
    bEff = sb ? ((~ub) & mask) : ub;
    full = ua + bEff + (sb ? 1 : int'(c));
    rs   = 8'(full & mask);
    rc   = ((full >> n) & 1) == 1;
    sa   = (ua >= (1 << (n - 1))) ? ua - (1 << n) : ua;
    sbv  = (ub >= (1 << (n - 1))) ? ub - (1 << n) : ub;
    sr   = sb ? (sa - sbv) : (sa + sbv + int'(c));
    ro   = (sr > (1 << (n - 1)) - 1) || (sr < -(1 << (n - 1)));
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for ready, presents one operation for a single accept edge, then scrambles inputs.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c, input logic sb);
    int waited = 0;
    while (!obsIReady && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("readyBeforeAccept", obsIReady, 1);
    aIn = a; bIn = b; cinIn = c;
`ifdef ADDER_SERIAL_SUB_EN
    subIn = sb;
`endif
    iValid = 1'b1;
    @(posedge clk); #1;
    iValid = 1'b0;
    aIn = 8'($urandom); bIn = 8'($urandom); cinIn = 1'($urandom);
`ifdef ADDER_SERIAL_SUB_EN
    subIn = 1'($urandom);
`endif
  endtask

  // Counts edges to o_valid, checks i_ready stays low, then compares against expS/expCout/expOvf.
  task automatic waitResult(input string tag);
    int cycles = 0;
    do begin
      checkOutput({tag, ".busy"}, obsIReady, 0);
      @(posedge clk); #1;
      cycles++;
    end while (!obsOValid && cycles < 40);
    checkOutput({tag, ".latency"}, cycles, latencyOf(sel));
    checkOutput({tag, ".s"}, obsS, expS);
    checkOutput({tag, ".cout"}, obsCout, expCout);
    checkOutput({tag, ".ovf"}, obsOvf, expOvf);
  endtask

  task automatic handoff(input string tag);
    oReady = 1'b1;
    @(posedge clk); #1;
    oReady = 1'b0;
    checkOutput({tag, ".readyAfter"}, obsIReady, 1);
    checkOutput({tag, ".validAfter"}, obsOValid, 0);
  endtask

  task automatic runDirected(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic c, input logic sb,
                             input logic [7:0] es, input logic ec, input logic eo);
    expS = es; expCout = ec; expOvf = eo;
    applyStimulus(a, b, c, sb);
    waitResult(tag);
    handoff(tag);
  endtask

  task automatic runRandom(input string tag, input int count);
    logic [7:0] a, b;
    logic c, sb;
    for (int i = 0; i < count; i++) begin
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
`ifdef ADDER_SERIAL_SUB_EN
      sb = 1'($urandom);
`else
      sb = 1'b0;
`endif
      refModel(widthOf(sel), a, b, c, sb, expS, expCout, expOvf);
      applyStimulus(a, b, c, sb);
      waitResult(tag);
      handoff(tag);
    end
  endtask

  initial begin
    rst = 1'b1; iValid = 1'b0; oReady = 1'b0; sel = 0;
    aIn = '0; bIn = '0; cinIn = 1'b0;
`ifdef ADDER_SERIAL_SUB_EN
    subIn = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int k = 0; k < 3; k++) begin
      sel = k;
      #0;
      checkOutput("reset.iReady", obsIReady, 1);
      checkOutput("reset.oValid", obsOValid, 0);
      checkOutput("reset.s", obsS, 0);
      checkOutput("reset.cout", obsCout, 0);
      checkOutput("reset.ovf", obsOvf, 0);
    end
    sel = 0;

    runDirected("add0F01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    runDirected("addFF01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    runDirected("add7F01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    runDirected("add8080", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    runDirected("addFFFFc", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);

    // Backpressure: result must hold while new operands are offered and refused.
    expS = 8'h87; expCout = 1'b0; expOvf = 1'b1;
    applyStimulus(8'h3C, 8'h4B, 1'b0, 1'b0);
    waitResult("bp");
    for (int i = 0; i < 5; i++) begin
      iValid = 1'b1; aIn = 8'($urandom); bIn = 8'($urandom); cinIn = 1'($urandom);
      @(posedge clk); #1;
      checkOutput("bp.holdS", obsS, expS);
      checkOutput("bp.holdCout", obsCout, expCout);
      checkOutput("bp.holdOvf", obsOvf, expOvf);
      checkOutput("bp.holdValid", obsOValid, 1);
      checkOutput("bp.holdReady", obsIReady, 0);
    end
    iValid = 1'b0;
    handoff("bp");

    // Reset two slices into an operation aborts it cleanly.
    applyStimulus(8'hAB, 8'h11, 1'b1, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort.iReady", obsIReady, 1);
    checkOutput("abort.oValid", obsOValid, 0);
    checkOutput("abort.s", obsS, 0);
    runDirected("afterAbort", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);

`ifdef ADDER_SERIAL_SUB_EN
    runDirected("sub0507", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    runDirected("sub8001", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);
`endif

    runRandom("rand8x2", 60);

    sel = 1;
    runDirected("n4add99", 8'h09, 8'h09, 1'b0, 1'b0, 8'h02, 1'b1, 1'b1);
    runRandom("rand4x4", 20);

    sel = 2;
    runRandom("rand6x1", 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
